// File: rtl/master_tx_ltssm_pkg.sv
// Encodings shared by the master TX and RX LTSSM controllers.
package master_tx_ltssm_pkg;

  typedef enum logic [3:0] {
    detectQuiet                  = 4'd0,
    detectActive                 = 4'd1,
    pollingActive                = 4'd2,
    pollingConfiguration         = 4'd3,
    configurationLinkWidthStart  = 4'd4,
    configurationLinkWidthAccept = 4'd5,
    configurationLanenumWait     = 4'd6,
    configurationLanenumAccept   = 4'd7,
    configurationComplete        = 4'd8,
    configurationIdle            = 4'd9
  } substateT;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_IDLE = 3'd3,
    OS_EIOS = 3'd4
  } osTypeT;

  typedef enum logic [1:0] {
    TX_WAIT = 2'd0,
    TX_SEND = 2'd1,
    TX_DONE = 2'd2
  } txStateT;

  localparam logic [7:0] PAD_SYMBOL = 8'hF7;

endpackage

// File: rtl/master_tx_ltssm_os_counter.sv
// Saturating count of ordered sets sent in the current substate, with threshold compare.
module tx_os_counter #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             countEn,
  input  logic [CNT_W-1:0] threshold,
  output logic             reached
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over counting; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (countEn && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign reached = (cnt >= threshold);

endmodule

// File: rtl/master_tx_ltssm.sv
// Transmit-side LTSSM controller: picks the ordered set for each training substate and
// pulses finish once enough have been sent for the main LTSSM to advance.
module master_tx_ltssm
  import master_tx_ltssm_pkg::*;
#(
  parameter int MAXLANES      = 16,
  parameter int POLL_TS1_MIN  = 1024,
  parameter int TS_AFTER_RX   = 16,
  parameter int IDLE_AFTER_RX = 16,
  parameter int CNT_W         = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          substate,
  input  logic                rxSubstateDone,
  input  logic                osSent,
  input  logic                receiverDetected,
  input  logic [4:0]          numberOfDetectedLanes,
  input  logic [7:0]          linkNumber,
  output logic                finish,
  output logic [2:0]          osType,
  output logic                osGenEnable,
  output logic [7:0]          linkNumOut,
  output logic [MAXLANES-1:0] laneNumPad,
  output logic                txElecIdle,
  output logic                txDetectRx,
  output logic                disableScrambler
);

  function automatic logic [MAXLANES-1:0] lanePadMask(input logic [4:0] lanes);
    logic [MAXLANES-1:0] mask;
    logic supported;
    mask = '1;
    supported = (lanes == 5'd1) || (lanes == 5'd2) || (lanes == 5'd4) ||
                (lanes == 5'd8) || (lanes == 5'd16);
    if (supported && (int'(lanes) <= MAXLANES)) begin
      for (int i = 0; i < MAXLANES; i++) begin
        if (i < int'(lanes)) mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

  txStateT             state, stateNx;
  logic [3:0]          lastSubstate, lastSubstateNx;
  logic                rxSeen, rxSeenNx;
  logic                subChanged, exitCond, countAll, rxGated;
  logic                cntClear, cntEn, cntReached;
  logic [CNT_W-1:0]    cntThreshold;
  osTypeT              sendOsType;
  logic                sendElecIdle, sendDetect;
  logic [7:0]          sendLink;
  logic [MAXLANES-1:0] sendPad;

  // Exit rule and counting mode of the substate currently being served.
  always_comb begin
    subChanged   = (substate != lastSubstate);
    cntThreshold = CNT_W'(TS_AFTER_RX);
    countAll     = 1'b0;
    rxGated      = 1'b0;
    exitCond     = 1'b0;
    case (substateT'(lastSubstate))
      detectQuiet:  exitCond = 1'b1;
      detectActive: exitCond = receiverDetected;
      pollingActive: begin
        countAll     = 1'b1;
        cntThreshold = CNT_W'(POLL_TS1_MIN);
        exitCond     = cntReached;
      end
      pollingConfiguration, configurationLinkWidthStart, configurationLinkWidthAccept,
      configurationLanenumWait, configurationLanenumAccept, configurationComplete: begin
        rxGated  = 1'b1;
        exitCond = rxSeen && cntReached;
      end
      configurationIdle: begin
        rxGated      = 1'b1;
        cntThreshold = CNT_W'(IDLE_AFTER_RX);
        exitCond     = rxSeen && cntReached;
      end
      default: ;
    endcase
  end

  // A substate change always wins: it relatches and restarts SEND, even mid-substate.
  always_comb begin
    stateNx        = state;
    lastSubstateNx = lastSubstate;
    rxSeenNx       = rxSeen;
    cntClear       = 1'b0;
    case (state)
      TX_WAIT: begin
        if (subChanged) begin
          lastSubstateNx = substate;
          rxSeenNx       = 1'b0;
          cntClear       = 1'b1;
          stateNx        = TX_SEND;
        end
      end
      TX_SEND: begin
        if (subChanged) begin
          lastSubstateNx = substate;
          rxSeenNx       = 1'b0;
          cntClear       = 1'b1;
        end else begin
          if (rxSubstateDone) rxSeenNx = 1'b1;
          if (exitCond) stateNx = TX_DONE;
        end
      end
      TX_DONE: stateNx = TX_WAIT;
      default: stateNx = TX_WAIT;
    endcase
  end

  assign cntEn = (state == TX_SEND) && !subChanged && osSent &&
                 (countAll || (rxGated && (rxSeen || rxSubstateDone)));

  tx_os_counter #(.CNT_W(CNT_W)) osCounter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cntClear),
    .countEn   (cntEn),
    .threshold (cntThreshold),
    .reached   (cntReached)
  );

  // Field values for the substate that will be served next cycle.
  always_comb begin
    sendOsType   = OS_NONE;
    sendElecIdle = 1'b1;
    sendDetect   = 1'b0;
    sendLink     = PAD_SYMBOL;
    sendPad      = '1;
    case (substateT'(lastSubstateNx))
      detectActive: sendDetect = 1'b1;
      pollingActive, configurationLinkWidthStart: begin
        sendOsType   = OS_TS1;
        sendElecIdle = 1'b0;
      end
      pollingConfiguration: begin
        sendOsType   = OS_TS2;
        sendElecIdle = 1'b0;
      end
      configurationLinkWidthAccept, configurationLanenumWait, configurationLanenumAccept: begin
        sendOsType   = OS_TS1;
        sendElecIdle = 1'b0;
        sendLink     = linkNumber;
        sendPad      = lanePadMask(numberOfDetectedLanes);
      end
      configurationComplete: begin
        sendOsType   = OS_TS2;
        sendElecIdle = 1'b0;
        sendLink     = linkNumber;
        sendPad      = lanePadMask(numberOfDetectedLanes);
      end
      configurationIdle: begin
        sendOsType   = OS_IDLE;
        sendElecIdle = 1'b0;
        sendLink     = linkNumber;
        sendPad      = lanePadMask(numberOfDetectedLanes);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= TX_WAIT;
      lastSubstate <= 4'hF;
      rxSeen       <= 1'b0;
    end else begin
      state        <= stateNx;
      lastSubstate <= lastSubstateNx;
      rxSeen       <= rxSeenNx;
    end
  end

  // Outside SEND the lane fields and osType hold, so DONE never glitches to NONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finish      <= 1'b0;
      osType      <= OS_NONE;
      osGenEnable <= 1'b0;
      linkNumOut  <= PAD_SYMBOL;
      laneNumPad  <= '1;
      txElecIdle  <= 1'b1;
      txDetectRx  <= 1'b0;
    end else begin
      finish      <= (stateNx == TX_DONE);
      osGenEnable <= (stateNx == TX_SEND) && (sendOsType != OS_NONE);
      txDetectRx  <= (stateNx == TX_SEND) && sendDetect;
      if (stateNx == TX_SEND) begin
        osType     <= sendOsType;
        txElecIdle <= sendElecIdle;
        linkNumOut <= sendLink;
        laneNumPad <= sendPad;
      end
    end
  end

  assign disableScrambler = 1'b1;

endmodule

// File: tb/tb_master_tx_ltssm.sv
// Randomized scenario bench for master_tx_ltssm against a per-substate reference model.
module tb_master_tx_ltssm;

  localparam int MAXLANES      = 16;
  localparam int POLL_TS1_MIN  = 1024;
  localparam int TS_AFTER_RX   = 16;
  localparam int IDLE_AFTER_RX = 16;
  localparam int CNT_W         = 11;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          substate;
  logic                rxSubstateDone, osSent, receiverDetected;
  logic [4:0]          numberOfDetectedLanes;
  logic [7:0]          linkNumber;
  logic                finish, osGenEnable, txElecIdle, txDetectRx, disableScrambler;
  logic [2:0]          osType;
  logic [7:0]          linkNumOut;
  logic [MAXLANES-1:0] laneNumPad;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  master_tx_ltssm #(
    .MAXLANES(MAXLANES), .POLL_TS1_MIN(POLL_TS1_MIN), .TS_AFTER_RX(TS_AFTER_RX),
    .IDLE_AFTER_RX(IDLE_AFTER_RX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .substate(substate), .rxSubstateDone(rxSubstateDone),
    .osSent(osSent), .receiverDetected(receiverDetected),
    .numberOfDetectedLanes(numberOfDetectedLanes), .linkNumber(linkNumber),
    .finish(finish), .osType(osType), .osGenEnable(osGenEnable), .linkNumOut(linkNumOut),
    .laneNumPad(laneNumPad), .txElecIdle(txElecIdle), .txDetectRx(txDetectRx),
    .disableScrambler(disableScrambler)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what each substate transmits, straight from the substate rules.
  function automatic logic [2:0] expOsType(input int sub);
    if (sub == 2 || (sub >= 4 && sub <= 7)) return 3'd1;
    if (sub == 3 || sub == 8) return 3'd2;
    if (sub == 9) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [15:0] expPad(input int sub, input int lanes);
    logic [15:0] m;
    m = 16'hFFFF;
    if (sub >= 5 && sub <= 9 &&
        (lanes == 1 || lanes == 2 || lanes == 4 || lanes == 8 || lanes == 16))
      m = m << lanes;
    return m;
  endfunction

  function automatic logic [7:0] expLink(input int sub, input logic [7:0] ln);
    return (sub >= 5 && sub <= 9) ? ln : 8'hF7;
  endfunction

  function automatic int pickLanes();
    int choices[8] = '{1, 2, 3, 4, 8, 16, 0, 5};
    return choices[$urandom_range(0, 7)];
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({finish, osType, osGenEnable, txElecIdle, txDetectRx, disableScrambler} !== 8'b0_000_0_1_0_1) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b",
               {finish, osType, osGenEnable, txElecIdle, txDetectRx, disableScrambler}, 8'b0_000_0_1_0_1);
    end
    vectors++;
    if ({linkNumOut, laneNumPad} !== {8'hF7, 16'hFFFF}) begin
      miscompares++;
      $display("[TB] FAIL reset_fields: got %h expected %h", {linkNumOut, laneNumPad}, {8'hF7, 16'hFFFF});
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({finish, osGenEnable} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %b expected %b", {finish, osGenEnable}, 2'b00);
    end
  endtask

  task automatic test_detect_quiet();
    substate = 4'd0;
    tick();
    vectors++;
    if ({finish, osType, osGenEnable, txElecIdle} !== 6'b0_000_0_1) begin
      miscompares++;
      $display("[TB] FAIL quiet_send: got %b expected %b", {finish, osType, osGenEnable, txElecIdle}, 6'b0_000_0_1);
    end
    tick();
    vectors++;
    if (finish !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL quiet_finish: got %b expected 1", finish);
    end
    tick();
    vectors++;
    if (finish !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL quiet_pulse: got %b expected 0", finish);
    end
  endtask

  task automatic test_polling_active();
    substate = 4'd2;
    tick();
    vectors++;
    if ({osType, osGenEnable, txElecIdle, linkNumOut, laneNumPad} !== {expOsType(2), 1'b1, 1'b0, 8'hF7, 16'hFFFF}) begin
      miscompares++;
      $display("[TB] FAIL poll_fields: got %h expected %h", {osType, osGenEnable, txElecIdle, linkNumOut, laneNumPad},
               {expOsType(2), 1'b1, 1'b0, 8'hF7, 16'hFFFF});
    end
    for (int k = 1; k <= POLL_TS1_MIN; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      osSent = 1'b1;
      tick();
      osSent = 1'b0;
      vectors++;
      if ({finish, osType, osGenEnable} !== {1'b0, expOsType(2), 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL poll_run%0d: got %b expected %b", k, {finish, osType, osGenEnable}, {1'b0, expOsType(2), 1'b1});
      end
    end
    tick();
    vectors++;
    if ({finish, osType, osGenEnable} !== {1'b1, expOsType(2), 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL poll_finish: got %b expected %b", {finish, osType, osGenEnable}, {1'b1, expOsType(2), 1'b0});
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({finish, osGenEnable} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL poll_no_rerequest: got %b expected %b", {finish, osGenEnable}, 2'b00);
      end
    end
  endtask

  task automatic test_detect_active();
    int waitCycles;
    waitCycles = $urandom_range(3, 12);
    substate = 4'd1;
    receiverDetected = 1'b0;
    tick();
    for (int k = 0; k < waitCycles; k++) begin
      vectors++;
      if ({finish, txDetectRx, txElecIdle, osGenEnable} !== 4'b0110) begin
        miscompares++;
        $display("[TB] FAIL detect_wait: got %b expected %b", {finish, txDetectRx, txElecIdle, osGenEnable}, 4'b0110);
      end
      tick();
    end
    receiverDetected = 1'b1;
    tick();
    receiverDetected = 1'b0;
    vectors++;
    if ({finish, txDetectRx, txElecIdle} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL detect_finish: got %b expected %b", {finish, txDetectRx, txElecIdle}, 3'b101);
    end
    tick();
  endtask

  task automatic test_config_complete();
    int lanes, pre, post, same;
    lanes = pickLanes();
    numberOfDetectedLanes = 5'(lanes);
    linkNumber = 8'($urandom_range(0, 255));
    substate = 4'd8;
    tick();
    vectors++;
    if ({osType, linkNumOut, laneNumPad} !== {expOsType(8), expLink(8, linkNumber), expPad(8, lanes)}) begin
      miscompares++;
      $display("[TB] FAIL cc_fields: got %h expected %h", {osType, linkNumOut, laneNumPad},
               {expOsType(8), expLink(8, linkNumber), expPad(8, lanes)});
    end
    pre = $urandom_range(16, 24);
    for (int k = 0; k < pre; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      osSent = 1'b1;
      tick();
      osSent = 1'b0;
      vectors++;
      if (finish !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL cc_pre_rx: got %b expected 0", finish);
      end
    end
    same = $urandom_range(0, 1);
    rxSubstateDone = 1'b1;
    osSent = 1'(same);
    tick();
    rxSubstateDone = 1'b0;
    osSent = 1'b0;
    post = same;
    while (post < TS_AFTER_RX) begin
      repeat ($urandom_range(0, 2)) tick();
      osSent = 1'b1;
      tick();
      osSent = 1'b0;
      post++;
      vectors++;
      if ({finish, osType} !== {1'b0, expOsType(8)}) begin
        miscompares++;
        $display("[TB] FAIL cc_post_rx%0d: got %b expected %b", post, {finish, osType}, {1'b0, expOsType(8)});
      end
    end
    tick();
    vectors++;
    if ({finish, osType, osGenEnable} !== {1'b1, expOsType(8), 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL cc_finish: got %b expected %b", {finish, osType, osGenEnable}, {1'b1, expOsType(8), 1'b0});
    end
    tick();
  endtask

  task automatic test_lane_fields();
    int sub, lanes;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        sub = 7;
        lanes = 4;
        linkNumber = 8'h05;
      end else begin
        sub = 5 + (i % 3);
        lanes = pickLanes();
        linkNumber = 8'($urandom_range(0, 255));
      end
      substate = 4'(sub);
      numberOfDetectedLanes = 5'(lanes);
      tick();
      if (i == 0) begin
        vectors++;
        if ({linkNumOut, laneNumPad} !== {8'h05, 16'hFFF0}) begin
          miscompares++;
          $display("[TB] FAIL lanenum_accept4: got %h expected %h", {linkNumOut, laneNumPad}, {8'h05, 16'hFFF0});
        end
      end
      vectors++;
      if ({finish, osType, osGenEnable, linkNumOut, laneNumPad} !==
          {1'b0, expOsType(sub), 1'b1, expLink(sub, linkNumber), expPad(sub, lanes)}) begin
        miscompares++;
        $display("[TB] FAIL lane_fields sub%0d lanes%0d: got %h expected %h", sub, lanes,
                 {finish, osType, osGenEnable, linkNumOut, laneNumPad},
                 {1'b0, expOsType(sub), 1'b1, expLink(sub, linkNumber), expPad(sub, lanes)});
      end
    end
  endtask

  task automatic test_abort();
    substate = 4'd2;
    tick();
    for (int k = 0; k < 500; k++) begin
      repeat ($urandom_range(0, 1)) tick();
      osSent = 1'b1;
      tick();
      osSent = 1'b0;
    end
    vectors++;
    if ({finish, osType} !== {1'b0, expOsType(2)}) begin
      miscompares++;
      $display("[TB] FAIL abort_poll: got %b expected %b", {finish, osType}, {1'b0, expOsType(2)});
    end
    substate = 4'd3;
    tick();
    vectors++;
    if ({finish, osType, linkNumOut} !== {1'b0, expOsType(3), 8'hF7}) begin
      miscompares++;
      $display("[TB] FAIL abort_switch: got %h expected %h", {finish, osType, linkNumOut}, {1'b0, expOsType(3), 8'hF7});
    end
    rxSubstateDone = 1'b1;
    tick();
    rxSubstateDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (finish !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort_cnt_restart: got %b expected 0", finish);
      end
    end
    for (int k = 0; k < TS_AFTER_RX; k++) begin
      osSent = 1'b1;
      tick();
      osSent = 1'b0;
    end
    vectors++;
    if (finish !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_early: got %b expected 0", finish);
    end
    tick();
    vectors++;
    if (finish !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_finish: got %b expected 1", finish);
    end
    tick();
  endtask

  task automatic test_reset_mid_idle();
    int lanes;
    lanes = pickLanes();
    numberOfDetectedLanes = 5'(lanes);
    linkNumber = 8'($urandom_range(0, 255));
    substate = 4'd9;
    tick();
    vectors++;
    if ({osType, osGenEnable, linkNumOut, laneNumPad} !== {expOsType(9), 1'b1, expLink(9, linkNumber), expPad(9, lanes)}) begin
      miscompares++;
      $display("[TB] FAIL idle_fields: got %h expected %h", {osType, osGenEnable, linkNumOut, laneNumPad},
               {expOsType(9), 1'b1, expLink(9, linkNumber), expPad(9, lanes)});
    end
    rxSubstateDone = 1'b1;
    osSent = 1'b1;
    tick();
    rxSubstateDone = 1'b0;
    repeat (8) tick();
    osSent = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if ({finish, osType, osGenEnable, txElecIdle, linkNumOut, laneNumPad} !== {1'b0, 3'd0, 1'b0, 1'b1, 8'hF7, 16'hFFFF}) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %h expected %h", {finish, osType, osGenEnable, txElecIdle, linkNumOut, laneNumPad},
               {1'b0, 3'd0, 1'b0, 1'b1, 8'hF7, 16'hFFFF});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({finish, osGenEnable} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL reset_hold: got %b expected %b", {finish, osGenEnable}, 2'b00);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    int post;
    tick();
    vectors++;
    if ({osType, osGenEnable} !== {expOsType(9), 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle_restart: got %b expected %b", {osType, osGenEnable}, {expOsType(9), 1'b1});
    end
    rxSubstateDone = 1'b1;
    osSent = 1'b1;
    tick();
    rxSubstateDone = 1'b0;
    osSent = 1'b0;
    post = 1;
    while (post < IDLE_AFTER_RX) begin
      repeat ($urandom_range(0, 2)) tick();
      osSent = 1'b1;
      tick();
      osSent = 1'b0;
      post++;
    end
    vectors++;
    if (finish !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle_early: got %b expected 0", finish);
    end
    tick();
    vectors++;
    if ({finish, osType} !== {1'b1, expOsType(9)}) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle_finish: got %b expected %b", {finish, osType}, {1'b1, expOsType(9)});
    end
    substate = 4'd8;
    tick();
    vectors++;
    if ({finish, osGenEnable} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL b2b_wait: got %b expected %b", {finish, osGenEnable}, 2'b00);
    end
    tick();
    vectors++;
    if ({finish, osType, osGenEnable} !== {1'b0, expOsType(8), 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL b2b_next_send: got %b expected %b", {finish, osType, osGenEnable}, {1'b0, expOsType(8), 1'b1});
    end
  endtask

  initial begin
    reset                 = 1'b0;
    substate              = 4'hF;
    rxSubstateDone        = 1'b0;
    osSent                = 1'b0;
    receiverDetected      = 1'b0;
    numberOfDetectedLanes = 5'd4;
    linkNumber            = 8'h00;
    test_reset();
    test_detect_quiet();
    test_polling_active();
    test_detect_active();
    test_config_complete();
    test_lane_fields();
    test_abort();
    test_reset_mid_idle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
